// File: rtl/fifo_fwft_thr.sv
// First-word-fall-through circular-buffer FIFO with fill level, almost-full/empty thresholds and flush.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo_fwft_thr #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         write,
    input  logic [DATA_WIDTH-1:0]        datain,
    input  logic                         read,
    output logic [DATA_WIDTH-1:0]        dataout,
    output logic                         val,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         almost_full,
    output logic                         almost_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic                         err_clr,
    output logic                         overflow,
    output logic                         underflow
`endif
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("fifo_fwft_thr: DEPTH must be >= 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("fifo_fwft_thr: AF_LEVEL must be in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
            $error("fifo_fwft_thr: AE_LEVEL must be in 0..AF_LEVEL-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  wr_ok, rd_ok;

    assign val          = (level_q != '0);
    assign full         = (level_q == LW'(DEPTH));
    assign almost_full  = (level_q >= LW'(AF_LEVEL));
    assign almost_empty = (level_q <= LW'(AE_LEVEL));
    assign level        = level_q;
    assign dataout      = mem_q[rd_ptr_q];

    // A write into a full FIFO is only legal when the same-cycle pop frees a slot.
    assign wr_ok = write & (~full | read);
    assign rd_ok = read & val;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                level_d = level_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is never reset; a flush or reset in the same cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && wr_ok) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = (write & full & ~read) | (overflow_q & ~err_clr);
        underflow_d = (read & ~val) | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
